// File: rtl/fp_multiplier_issue_scheduler.sv
// Round-robin issue scheduler for one shared, non-stallable pipelined FP32 multiplier.
// Issue is credit-gated so every in-flight result is guaranteed a slot in the output FIFO.
module fp_multiplier_issue_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0][31:0]      req_multiplicand_i,
    input  logic [NUM_REQ-1:0][31:0]      req_multiplier_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag_i,
    output logic                          mul_valid_o,
    output logic [31:0]                   mul_multiplicand_o,
    output logic [31:0]                   mul_multiplier_o,
    input  logic                          mul_valid_i,
    input  logic [31:0]                   mul_result_i,
    input  logic [2:0]                    mul_flags_i,
    input  logic [2:0]                    mul_round_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_result_o,
    output logic [2:0]                    out_flags_o,
    output logic [2:0]                    out_round_o,
    output logic [ID_W-1:0]               out_req_id_o,
    output logic [TAG_W-1:0]              out_tag_o,
    output logic                          busy_o,
    output logic                          error_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic             sq;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } slot_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [2:0]       flags;
        logic [2:0]       rnd;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  idx;
    logic             win_found;
    logic             can_issue;
    logic             issue;
    slot_t            slot_q [LATENCY];
    slot_t            tail;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head;
    logic             push;
    logic             pop;
    logic             error_q;

    // First valid requester at or after ptr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign can_issue          = (int'(cnt_q) + int'(inflight_q)) < FIFO_DEPTH;
    assign issue              = win_found & can_issue & ~flush_i;
    assign req_ready_o        = issue ? (NUM_REQ'(1) << win_id) : '0;
    assign mul_valid_o        = issue;
    assign mul_multiplicand_o = issue ? req_multiplicand_i[win_id] : '0;
    assign mul_multiplier_o   = issue ? req_multiplier_i[win_id]   : '0;

    assign tail = slot_q[LATENCY-1];
    assign push = tail.vld & ~tail.sq & mul_valid_i & ~flush_i;
    assign pop  = (cnt_q != '0) & out_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else if (issue) begin
            ptr_q <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
        end
    end

    // Tag pipe mirrors the multiplier; flush squashes live slots but keeps them counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LATENCY; i++) slot_q[i] <= '0;
        end else begin
            slot_q[0] <= '{vld: issue, sq: 1'b0, id: win_id, tag: req_tag_i[win_id]};
            for (int i = 1; i < LATENCY; i++) begin
                slot_q[i] <= '{vld: slot_q[i-1].vld,
                               sq:  slot_q[i-1].sq | (flush_i & slot_q[i-1].vld),
                               id:  slot_q[i-1].id,
                               tag: slot_q[i-1].tag};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
            error_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(tail.vld);
            if (mul_valid_i != tail.vld) error_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= '{result: mul_result_i, flags: mul_flags_i, rnd: mul_round_i,
                                   id: tail.id, tag: tail.tag};
    end

    assign head         = mem_q[rd_q];
    assign out_valid_o  = cnt_q != '0;
    assign out_result_o = out_valid_o ? head.result : '0;
    assign out_flags_o  = out_valid_o ? head.flags  : '0;
    assign out_round_o  = out_valid_o ? head.rnd    : '0;
    assign out_req_id_o = out_valid_o ? head.id     : '0;
    assign out_tag_o    = out_valid_o ? head.tag    : '0;
    assign busy_o       = (inflight_q != '0) | (cnt_q != '0);
    assign error_o      = error_q;

endmodule

// File: tb/tb_fp_multiplier_issue_scheduler.sv
// Bench for fp_multiplier_issue_scheduler: queue-based reference model checked every cycle,
// a fake fixed-latency multiplier, directed scenarios and a randomized soak.
module tb_fp_multiplier_issue_scheduler;
    localparam int NR  = 2;
    localparam int LAT = 7;
    localparam int DEP = 4;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    flush, inject, out_ready;
    logic [NR-1:0]           req_valid, req_ready;
    logic [NR-1:0][31:0]     req_a, req_b;
    logic [NR-1:0][TW-1:0]   req_tag;
    logic                    mul_vo, mul_vi;
    logic [31:0]             mul_a, mul_b, mul_res;
    logic [2:0]              mul_fl, mul_rnd;
    logic                    out_valid, busy, err;
    logic [31:0]             out_res;
    logic [2:0]              out_fl, out_rnd;
    logic [0:0]              out_id;
    logic [TW-1:0]           out_tag;

    fp_multiplier_issue_scheduler #(.NUM_REQ(NR), .LATENCY(LAT), .FIFO_DEPTH(DEP), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_multiplicand_i(req_a), .req_multiplier_i(req_b), .req_tag_i(req_tag),
        .mul_valid_o(mul_vo), .mul_multiplicand_o(mul_a), .mul_multiplier_o(mul_b),
        .mul_valid_i(mul_vi), .mul_result_i(mul_res), .mul_flags_i(mul_fl), .mul_round_i(mul_rnd),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_res),
        .out_flags_o(out_fl), .out_round_o(out_rnd), .out_req_id_o(out_id), .out_tag_o(out_tag),
        .busy_o(busy), .error_o(err));

    // Truncating FP32 multiply for normal operands; enough for a stand-in multiplier.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin m = p[46:24]; e = e + 10'd1; end
        else m = p[45:23];
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Stand-in multiplier: registers the issue, answers LAT cycles after mul_valid_o.
    typedef struct packed { logic v; logic [31:0] r; logic [2:0] f; logic [2:0] rd; } mres_t;
    mres_t mp [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) mp[i] <= '0;
        end else begin
            mp[0] <= '{v: mul_vo, r: fmul(mul_a, mul_b), f: mul_a[2:0] ^ mul_b[2:0], rd: mul_a[5:3] ^ mul_b[5:3]};
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_vi  = mp[LAT-1].v | inject;
    assign mul_res = mp[LAT-1].r;
    assign mul_fl  = mp[LAT-1].f;
    assign mul_rnd = mp[LAT-1].rd;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ops in flight carry their due cycle; the output FIFO is a plain queue.
    typedef struct {
        int          id;
        logic [TW-1:0] tag;
        logic [31:0] r;
        logic [2:0]  f;
        logic [2:0]  rd;
        int          due;
        bit          sq;
    } op_t;

    op_t inq[$];
    op_t fq[$];
    int  ptr, cyc;
    bit  merr;

    always @(negedge clk) begin
        if (!rst_n) begin
            inq.delete(); fq.delete();
            ptr = 0; cyc = 0; merr = 0;
        end else begin : model
            int  credits, w;
            bit  found, iss, ret;
            op_t e;
            credits = DEP - fq.size() - inq.size();
            found = 0; w = 0;
            for (int k = 0; k < NR; k++)
                if (!found && req_valid[(ptr + k) % NR]) begin found = 1; w = (ptr + k) % NR; end
            iss = found && credits > 0 && !flush;
            chk("req_ready", 32'(req_ready), iss ? (32'd1 << w) : 32'd0);
            chk("mul_valid", 32'(mul_vo), 32'(iss));
            if (iss) begin
                chk("mul_a", mul_a, req_a[w]);
                chk("mul_b", mul_b, req_b[w]);
            end
            chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
            if (fq.size() != 0) begin
                chk("out_result", out_res, fq[0].r);
                chk("out_flags", 32'(out_fl), 32'(fq[0].f));
                chk("out_round", 32'(out_rnd), 32'(fq[0].rd));
                chk("out_id", 32'(out_id), 32'(fq[0].id));
                chk("out_tag", 32'(out_tag), 32'(fq[0].tag));
            end
            chk("busy", 32'(busy), 32'(inq.size() != 0 || fq.size() != 0));
            chk("error", 32'(err), 32'(merr));

            ret = inq.size() != 0 && inq[0].due == cyc;
            if (mul_vi != ret) merr = 1;
            if (ret) e = inq.pop_front();
            if (fq.size() != 0 && out_ready && !flush) void'(fq.pop_front());
            if (flush) begin
                fq.delete();
                foreach (inq[i]) inq[i].sq = 1;
            end
            if (ret && !e.sq && mul_vi && !flush) fq.push_back(e);
            if (iss) begin
                e.id = w; e.tag = req_tag[w]; e.r = fmul(req_a[w], req_b[w]);
                e.f = req_a[w][2:0] ^ req_b[w][2:0]; e.rd = req_a[w][5:3] ^ req_b[w][5:3];
                e.due = cyc + LAT; e.sq = 0;
                inq.push_back(e);
                ptr = (w + 1) % NR;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        int ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
            tick();
        end
        chk(nm, ok, 1);
        tick();
    endtask

    task automatic count_issues(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mul_vo) c++;
            tick();
        end
    endtask

    task automatic count_outs(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) c++;
            tick();
        end
    endtask

    initial begin #1_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        int          lat, c;
        logic [31:0] r1;
        logic [0:0]  id1;
        logic [TW-1:0] tg1;
        logic [1:0]  exp_g [5];
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        flush = 0; inject = 0; out_ready = 0; req_valid = '0;
        req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(err), 0);
        chk("rst_mul_valid", 32'(mul_vo), 0);
        tick();

        // single multiply 2.0 * 3.0 from requester 0
        req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_tag[0] = 4'd5;
        req_valid = 2'b01; out_ready = 1;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_mul_valid", 32'(mul_vo), 1);
        chk("t1_mul_a", mul_a, 32'h40000000);
        tick();
        req_valid = 0;
        lat = -1; r1 = '0; id1 = '0; tg1 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid && lat < 0) begin lat = i; r1 = out_res; id1 = out_id; tg1 = out_tag; end
            tick();
        end
        // result back LAT cycles after issue, visible at the FIFO head one cycle later
        chk("t1_latency", lat, LAT + 1);
        chk("t1_result", r1, 32'h40C00000);
        chk("t1_id", 32'(id1), 0);
        chk("t1_tag", 32'(tg1), 5);

        // both requesters: pointer sits at 1 after the single req0 issue
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
            req_tag = {4'(2 * i + 1), 4'(2 * i)};
            @(negedge clk);
            chk("t2_grant", 32'(req_ready), 32'(exp_g[i]));
            tick();
        end
        req_valid = 0;
        wait_idle("t2_drain");

        // backpressure: credits cap issues at FIFO depth
        out_ready = 0; req_valid = 2'b01;
        count_issues(20, c);
        chk("t3_issues", c, 4);
        @(negedge clk);
        chk("t3_stalled", 32'(req_ready), 0);
        tick();
        out_ready = 1;
        @(negedge clk);
        chk("t3_pop_cycle_ready", 32'(req_ready), 0);
        tick();
        out_ready = 0;
        count_issues(15, c);
        chk("t3_one_more", c, 1);
        req_valid = 0; out_ready = 1;
        count_outs(20, c);
        chk("t3_drained", c, 4);
        wait_idle("t3_idle");

        // flush two cycles after the third issue
        req_valid = 2'b01;
        repeat (3) tick();
        req_valid = 0;
        tick();
        flush = 1;
        @(negedge clk);
        chk("t4_busy_at_flush", 32'(busy), 1);
        tick();
        flush = 0;
        count_outs(15, c);
        chk("t4_no_outputs", c, 0);
        @(negedge clk);
        chk("t4_idle", 32'(busy), 0);
        tick();
        out_ready = 0; req_valid = 2'b01;
        count_issues(6, c);
        chk("t4_credits_back", c, 4);
        req_valid = 0; out_ready = 1;
        count_outs(15, c);
        chk("t4_post_flush_outs", c, 4);
        wait_idle("t4_drain");

        // spurious multiplier result with nothing in flight
        inject = 1;
        tick();
        inject = 0;
        @(negedge clk);
        chk("t5_error", 32'(err), 1);
        chk("t5_fifo_empty", 32'(out_valid), 0);
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("t5_error_sticky", 32'(err), 1);
        tick();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        @(negedge clk);
        chk("t5_error_cleared", 32'(err), 0);
        tick();

        // async reset in the middle of a burst
        out_ready = 0;
        for (int i = 0; i < 15; i++) begin
            req_valid = NR'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
            req_tag = NR*TW'($urandom);
            tick();
        end
        @(posedge clk);
        #3 rst_n = 0; req_valid = 0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_error", 32'(err), 0);
        chk("t6_mul_valid", 32'(mul_vo), 0);
        tick();
        tick();
        rst_n = 1; req_valid = 2'b11;
        @(negedge clk);
        chk("t6_first_grant", 32'(req_ready), 32'h1);
        tick();

        // randomized soak
        for (int i = 0; i < 2000; i++) begin
            req_valid = NR'($urandom);
            req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
            req_tag = NR*TW'($urandom);
            out_ready = ($urandom % 10) < 7;
            flush = ($urandom % 40) == 0;
            tick();
        end
        req_valid = 0; flush = 0; out_ready = 1;
        wait_idle("rand_drain");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
